cache_ctrl: RTL

Cache controller directly upstream of the tag-matching CAM cache (cam2). It accepts single-word read requests by tag and looks the tag up in the CAM. On a miss it evicts a round-robin victim when the CAM is full, fetches the word from backing memory, fills the CAM, and returns the data. It also keeps saturating hit and miss counters for performance monitoring.

---
 rtl/cache_pkg.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/cache_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    EVICT  = 3'd2,
    FETCH  = 3'd3,
    FILL   = 3'd4
  } state_t;

  // CAM write strobe is active low.
  localparam logic CAM_WRITE_EN = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// Read-only cache controller in front of a tag-matching CAM: lookup, round-robin
// eviction when full, backing-memory fetch, fill, and hit/miss statistics.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WORDS     = 8,
  parameter int unsigned BITS      = 8,
  parameter int unsigned TAG_SZ    = 8,
  parameter int          ADDR_LEFT = $clog2(WORDS) - 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 req_valid,
  input  logic [TAG_SZ-1:0]    req_tag,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [BITS-1:0]      rsp_data,
  output logic [TAG_SZ-1:0]    cam_check_tag,
  output logic                 cam_read,
  input  logic [BITS-1:0]      cam_data,
  input  logic                 cam_hit,
  input  logic                 cam_full,
  output logic                 cam_write_,
  output logic [ADDR_LEFT:0]   cam_w_addr,
  output logic [BITS-1:0]      cam_wdata,
  output logic [TAG_SZ-1:0]    cam_new_tag,
  output logic                 cam_new_valid,
  output logic                 mem_req,
  output logic [TAG_SZ-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic [BITS-1:0]      mem_rdata,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  localparam int unsigned AW = ADDR_LEFT + 1;

  state_t            state_q, state_d;
  logic [TAG_SZ-1:0] tag_q, tag_d;
  logic [BITS-1:0]   data_q, data_d;
  logic [AW-1:0]     victim_q, victim_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0]   rsp_data_q, rsp_data_d;
  logic              hit_inc, miss_inc;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      data_q      <= '0;
      victim_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      victim_q    <= victim_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state and Moore decode of the CAM / memory strobes.
  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    data_d        = data_q;
    victim_d      = victim_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    req_ready     = 1'b0;
    cam_read      = 1'b0;
    cam_write_    = ~CAM_WRITE_EN;
    cam_new_valid = 1'b0;
    mem_req       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tag_d   = req_tag;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        cam_read = 1'b1;
        if (cam_hit) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cam_data;
          hit_inc     = 1'b1;
          state_d     = IDLE;
        end else begin
          miss_inc = 1'b1;
          state_d  = cam_full ? EVICT : FETCH;
        end
      end
      EVICT: begin
        cam_write_ = CAM_WRITE_EN;
        victim_d   = (victim_q == AW'(WORDS - 1)) ? '0 : victim_q + AW'(1);
        state_d    = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = FILL;
        end
      end
      FILL: begin
        // The CAM picks its first empty slot, i.e. the victim freed in EVICT.
        cam_write_    = CAM_WRITE_EN;
        cam_new_valid = 1'b1;
        rsp_valid_d   = 1'b1;
        rsp_data_d    = data_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cam_check_tag = tag_q;
  assign cam_new_tag   = tag_q;
  assign cam_wdata     = data_q;
  assign mem_addr      = tag_q;
  assign cam_w_addr    = victim_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_  (rst_),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_  (rst_),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

endmodule
